// File: rtl/fu_wb_serializer.sv
// fu_wb_serializer
//   Result stage behind a functional unit. Each FU output bundle (instruction id,
//   up to MAX_OPERANDS 64-bit results and a per-slot valid mask) is captured into
//   an in-order FIFO. The head entry is drained as one register-file write beat per
//   cycle, with slots in ascending order. A bundle with an empty mask drains as a
//   single completion-only beat. The FU output has no ready, so back-pressure is
//   returned to the issue stage through o_fu_can_issue.
//
// Ports
//   clk              clock, all state on rising edge
//   rst_n            asynchronous active-low reset
//   i_valid          FU bundle valid
//   i_inst_id        FU instruction id
//   i_data           MAX_OPERANDS x 64-bit results, slot s at [s*64 +: 64]
//   i_data_valid     per-slot result valid mask
//   o_fu_can_issue   at least ISSUE_SLACK free entries
//   o_wb_valid       write beat available
//   i_wb_ready       consumer accepts beat
//   o_wb_inst_id     instruction owning the beat
//   o_wb_slot        result slot of the beat
//   o_wb_data        result data
//   o_wb_write       1 = register write, 0 = completion-only beat
//   o_wb_last        final beat of the instruction
//   o_count          occupied FIFO entries
//   o_overflow       sticky, a bundle was dropped because the FIFO was full
module fu_wb_serializer #(
  parameter int INST_ID_BITS = 6,
  parameter int MAX_OPERANDS = 3,
  parameter int DEPTH        = 4,
  parameter int ISSUE_SLACK  = 2,
  localparam int SLOT_W = (MAX_OPERANDS > 1) ? $clog2(MAX_OPERANDS) : 1,
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_valid,
  input  logic [INST_ID_BITS-1:0]      i_inst_id,
  input  logic [MAX_OPERANDS*64-1:0]   i_data,
  input  logic [MAX_OPERANDS-1:0]      i_data_valid,
  output logic                         o_fu_can_issue,
  output logic                         o_wb_valid,
  input  logic                         i_wb_ready,
  output logic [INST_ID_BITS-1:0]      o_wb_inst_id,
  output logic [SLOT_W-1:0]            o_wb_slot,
  output logic [63:0]                  o_wb_data,
  output logic                         o_wb_write,
  output logic                         o_wb_last,
  output logic [CNT_W-1:0]             o_count,
  output logic                         o_overflow
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [INST_ID_BITS-1:0]    r_id   [DEPTH];
  logic [MAX_OPERANDS*64-1:0] r_data [DEPTH];
  logic [MAX_OPERANDS-1:0]    r_mask [DEPTH];

  logic [PTR_W-1:0]        r_rd_ptr;
  logic [PTR_W-1:0]        r_wr_ptr;
  logic [CNT_W-1:0]        r_count;
  logic [MAX_OPERANDS-1:0] r_rem;
  logic                    r_overflow;

  logic                    w_valid;
  logic [SLOT_W-1:0]       w_slot;
  logic [63:0]             w_data;
  logic [MAX_OPERANDS-1:0] w_rem_clr;
  logic                    w_last;
  logic                    w_write;
  logic                    w_xfer;
  logic                    w_pop;
  logic                    w_full;
  logic                    w_push;
  logic [PTR_W-1:0]        w_rd_next;

  assign w_valid = (r_count != '0);

  // Lowest set bit of the remaining mask: scanning downward, the last hit wins.
  always_comb begin
    w_slot = '0;
    w_data = '0;
    for (int i = MAX_OPERANDS - 1; i >= 0; i--) begin
      if (r_rem[i]) begin
        w_slot = SLOT_W'(i);
        w_data = r_data[r_rd_ptr][i*64 +: 64];
      end
    end
  end

  // An empty remaining mask only occurs for an all-zero bundle, which yields
  // last=1 and write=0 naturally.
  assign w_rem_clr = r_rem & ~(MAX_OPERANDS'(1) << w_slot);
  assign w_last    = (w_rem_clr == '0);
  assign w_write   = |r_rem;

  assign w_xfer    = w_valid & i_wb_ready;
  assign w_pop     = w_xfer & w_last;
  assign w_full    = (r_count == CNT_W'(DEPTH));
  assign w_push    = i_valid & (~w_full | w_pop);
  assign w_rd_next = r_rd_ptr + PTR_W'(1);

  assign o_wb_valid     = w_valid;
  assign o_wb_inst_id   = w_valid ? r_id[r_rd_ptr] : '0;
  assign o_wb_slot      = w_valid ? w_slot : '0;
  assign o_wb_data      = w_valid ? w_data : '0;
  assign o_wb_write     = w_valid & w_write;
  assign o_wb_last      = w_valid & w_last;
  assign o_count        = r_count;
  assign o_overflow     = r_overflow;
  assign o_fu_can_issue = (DEPTH - int'(r_count)) >= ISSUE_SLACK;

  // Storage needs no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_id[r_wr_ptr]   <= i_inst_id;
      r_data[r_wr_ptr] <= i_data;
      r_mask[r_wr_ptr] <= i_data_valid;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_rem      <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= w_rd_next;

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase

      if (i_valid && !w_push) r_overflow <= 1'b1;

      // The remaining mask follows whichever entry is head after this edge:
      // the next stored entry, or the bundle arriving into an emptying FIFO.
      if (w_pop) begin
        if (r_count > CNT_W'(1)) r_rem <= r_mask[w_rd_next];
        else if (w_push)         r_rem <= i_data_valid;
        else                     r_rem <= '0;
      end else if (w_xfer) begin
        r_rem <= w_rem_clr;
      end else if (!w_valid && w_push) begin
        r_rem <= i_data_valid;
      end
    end
  end

endmodule

// File: tb/tb_fu_wb_serializer.sv
module tb_fu_wb_serializer;

  localparam int IDW   = 6;
  localparam int NOP   = 3;
  localparam int DEPTH = 4;
  localparam int SLACK = 2;
  localparam int SW    = 2;
  localparam int CW    = 3;

  logic              clk;
  logic              rst_n;
  logic              i_valid;
  logic [IDW-1:0]    i_inst_id;
  logic [NOP*64-1:0] i_data;
  logic [NOP-1:0]    i_data_valid;
  logic              o_fu_can_issue;
  logic              o_wb_valid;
  logic              i_wb_ready;
  logic [IDW-1:0]    o_wb_inst_id;
  logic [SW-1:0]     o_wb_slot;
  logic [63:0]       o_wb_data;
  logic              o_wb_write;
  logic              o_wb_last;
  logic [CW-1:0]     o_count;
  logic              o_overflow;

  fu_wb_serializer #(
    .INST_ID_BITS(IDW), .MAX_OPERANDS(NOP), .DEPTH(DEPTH), .ISSUE_SLACK(SLACK)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .i_valid(i_valid), .i_inst_id(i_inst_id), .i_data(i_data), .i_data_valid(i_data_valid),
    .o_fu_can_issue(o_fu_can_issue), .o_wb_valid(o_wb_valid), .i_wb_ready(i_wb_ready),
    .o_wb_inst_id(o_wb_inst_id), .o_wb_slot(o_wb_slot), .o_wb_data(o_wb_data),
    .o_wb_write(o_wb_write), .o_wb_last(o_wb_last), .o_count(o_count), .o_overflow(o_overflow)
  );

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [SW-1:0]  slot;
    logic [63:0]    data;
    logic           wr;
    logic           last;
  } beat_t;

  // Model: the FIFO as a flat queue of pending beats plus an entry count.
  beat_t bq[$];
  int    m_entries;
  logic  m_ovf;

  int nvec;
  int nfail;

  localparam logic [63:0] DA = 64'hAAAA_0000_1111_2222;
  localparam logic [63:0] DB = 64'hBBBB_3333_4444_5555;
  localparam logic [63:0] DC = 64'hCCCC_6666_7777_8888;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_model();
    chk("wb_valid", 64'(o_wb_valid), 64'(bq.size() != 0));
    if (bq.size() != 0) begin
      chk("wb_inst_id", 64'(o_wb_inst_id), 64'(bq[0].id));
      chk("wb_slot",    64'(o_wb_slot),    64'(bq[0].slot));
      chk("wb_data",    o_wb_data,         bq[0].data);
      chk("wb_write",   64'(o_wb_write),   64'(bq[0].wr));
      chk("wb_last",    64'(o_wb_last),    64'(bq[0].last));
    end else begin
      chk("idle_outputs", {o_wb_data[31:0], 22'(o_wb_inst_id), 8'(o_wb_slot), o_wb_write, o_wb_last}, 64'd0);
    end
    chk("count",        64'(o_count),        64'(m_entries));
    chk("fu_can_issue", 64'(o_fu_can_issue), 64'((DEPTH - m_entries) >= SLACK));
    chk("overflow",     64'(o_overflow),     64'(m_ovf));
  endtask

  // Called right after a falling edge: applies inputs for the next rising edge,
  // advances the model across that edge, then checks at the following falling edge.
  task automatic step(input logic v, input logic [IDW-1:0] id, input logic [63:0] d0,
                      input logic [63:0] d1, input logic [63:0] d2, input logic [NOP-1:0] m,
                      input logic rdy);
    logic [63:0] dd[NOP];
    bit xfer, pop, acc;
    beat_t b;
    dd[0] = d0; dd[1] = d1; dd[2] = d2;
    i_valid      = v;
    i_inst_id    = id;
    i_data       = {d2, d1, d0};
    i_data_valid = m;
    i_wb_ready   = rdy;
    xfer = (bq.size() != 0) && rdy;
    pop  = xfer && bq[0].last;
    acc  = v && ((m_entries < DEPTH) || pop);
    if (xfer) void'(bq.pop_front());
    if (pop) m_entries--;
    if (acc) begin
      if (m == 0) begin
        b = '{id: id, slot: '0, data: '0, wr: 1'b0, last: 1'b1};
        bq.push_back(b);
      end else begin
        for (int s = 0; s < NOP; s++) begin
          if (m[s]) begin
            b = '{id: id, slot: SW'(s), data: dd[s], wr: 1'b1, last: ((m >> (s + 1)) == 0)};
            bq.push_back(b);
          end
        end
      end
      m_entries++;
    end else if (v) begin
      m_ovf = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    cmp_model();
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, '0, '0, '0, '0, '0, rdy);
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic drain();
    for (int i = 0; i < 200 && bq.size() != 0; i++) idle(1'b1);
    chk("drain_empty", 64'(o_count), 64'd0);
  endtask

  // Asynchronous reset between clock edges, released on a falling edge.
  task automatic do_reset();
    i_valid = 1'b0; i_wb_ready = 1'b0; i_data_valid = '0;
    #2 rst_n = 1'b0;
    #1;
    bq.delete();
    m_entries = 0;
    m_ovf     = 1'b0;
    chk("rst_async_valid", 64'(o_wb_valid), 64'd0);
    chk("rst_async_count", 64'(o_count),    64'd0);
    cmp_model();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] first_d, y;
    int pushed;
    logic v;
    nvec = 0; nfail = 0;
    m_entries = 0; m_ovf = 1'b0;
    rst_n = 1'b0; i_valid = 1'b0; i_inst_id = '0; i_data = '0; i_data_valid = '0; i_wb_ready = 1'b0;
    repeat (2) @(negedge clk);
    cmp_model();
    chk("reset_can_issue", 64'(o_fu_can_issue), 64'd1);
    rst_n = 1'b1;

    // 1: mask 101 -> slot0 then slot2, no slot1 beat
    step(1'b1, 6'd5, DA, DB, DC, 3'b101, 1'b1);
    chk("t1_b0_slot", 64'(o_wb_slot), 64'd0);
    chk("t1_b0_data", o_wb_data, DA);
    chk("t1_b0_last", 64'(o_wb_last), 64'd0);
    idle(1'b1);
    chk("t1_b1_slot", 64'(o_wb_slot), 64'd2);
    chk("t1_b1_data", o_wb_data, DC);
    chk("t1_b1_wl", {62'd0, o_wb_write, o_wb_last}, 64'd3);
    idle(1'b1);
    chk("t1_done", {61'd0, o_wb_valid, o_count[1:0]}, 64'd0);

    // 2: empty mask -> single completion-only beat
    step(1'b1, 6'd9, rnd64(), rnd64(), rnd64(), 3'b000, 1'b1);
    chk("t2_beat", {o_wb_data[59:0], o_wb_slot, o_wb_write, o_wb_last}, 64'd1);
    chk("t2_id", 64'(o_wb_inst_id), 64'd9);
    idle(1'b1);
    chk("t2_done", 64'(o_wb_valid), 64'd0);

    // 3: fill with consumer stalled, then overflow
    first_d = rnd64();
    step(1'b1, 6'd1, first_d, '0, '0, 3'b001, 1'b0);
    step(1'b1, 6'd2, rnd64(), '0, '0, 3'b001, 1'b0);
    chk("t3_can_issue_c2", 64'(o_fu_can_issue), 64'd1);
    step(1'b1, 6'd3, rnd64(), '0, '0, 3'b001, 1'b0);
    chk("t3_can_issue_c3", 64'(o_fu_can_issue), 64'd0);
    step(1'b1, 6'd4, rnd64(), '0, '0, 3'b001, 1'b0);
    chk("t3_head_data", o_wb_data, first_d);
    step(1'b1, 6'd5, rnd64(), '0, '0, 3'b001, 1'b0);
    chk("t3_overflow", 64'(o_overflow), 64'd1);
    chk("t3_count", 64'(o_count), 64'd4);
    chk("t3_head_id", 64'(o_wb_inst_id), 64'd1);
    do_reset();

    // 4: full FIFO, push on the same edge as the head pops
    for (int i = 0; i < 4; i++) step(1'b1, 6'(10 + i), rnd64(), '0, '0, 3'b001, 1'b0);
    step(1'b1, 6'd14, rnd64(), '0, '0, 3'b001, 1'b1);
    chk("t4_count", 64'(o_count), 64'd4);
    chk("t4_overflow", 64'(o_overflow), 64'd0);
    chk("t4_head_id", 64'(o_wb_inst_id), 64'd11);
    drain();

    // 5: 20 pushes obeying fu_can_issue, random ready
    pushed = 0;
    for (int c = 0; c < 500 && pushed < 20; c++) begin
      v = o_fu_can_issue && ($urandom_range(0, 3) != 0);
      step(v, 6'(pushed), rnd64(), rnd64(), rnd64(), 3'b001, 1'($urandom_range(0, 1)));
      if (v) pushed++;
    end
    chk("t5_pushed", 64'(pushed), 64'd20);
    drain();
    chk("t5_no_overflow", 64'(o_overflow), 64'd0);

    // 6: reset mid-drain, then fresh single-slot instruction
    step(1'b1, 6'd7, rnd64(), rnd64(), rnd64(), 3'b111, 1'b0);
    idle(1'b1);
    chk("t6_mid_slot", 64'(o_wb_slot), 64'd1);
    do_reset();
    y = rnd64();
    step(1'b1, 6'd3, rnd64(), y, rnd64(), 3'b010, 1'b1);
    chk("t6_slot", 64'(o_wb_slot), 64'd1);
    chk("t6_data", o_wb_data, y);
    chk("t6_wl", {62'd0, o_wb_write, o_wb_last}, 64'd3);
    idle(1'b1);
    chk("t6_done", 64'(o_wb_valid), 64'd0);

    // Random traffic, ignoring back-pressure so overflow is exercised too
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      step(1'($urandom_range(0, 1)), 6'($urandom), rnd64(), rnd64(), rnd64(),
           3'($urandom_range(0, 7)), 1'($urandom_range(0, 3) != 0));
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
